// File: rtl/aes_req_sched_if.sv
// Bus bundle between the requesters/consumer/AES core and the scheduler.
// slave is the scheduler's view, master is the environment's view.
interface aes_req_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]        req_vld;
  logic [NUM_REQ-1:0]        req_rdy;
  logic [NUM_REQ-1:0][127:0] req_key;
  logic [NUM_REQ-1:0][127:0] req_pt;
  logic                      st_aes;
  logic [127:0]              aes_key;
  logic [127:0]              plain_text;
  logic                      aes_done;
  logic [127:0]              cp_text;
  logic                      rsp_vld;
  logic                      rsp_rdy;
  logic [ID_W-1:0]           rsp_id;
  logic [127:0]              rsp_ct;
  logic                      rsp_err;
  logic                      busy;

  modport slave (
    input  req_vld, req_key, req_pt, aes_done, cp_text, rsp_rdy,
    output req_rdy, st_aes, aes_key, plain_text, rsp_vld, rsp_id, rsp_ct, rsp_err, busy
  );

  modport master (
    output req_vld, req_key, req_pt, aes_done, cp_text, rsp_rdy,
    input  req_rdy, st_aes, aes_key, plain_text, rsp_vld, rsp_id, rsp_ct, rsp_err, busy
  );
endinterface

// File: rtl/aes_req_sched.sv
// Round-robin scheduler sharing one AES core among NUM_REQ requesters.
// One job in flight: grant -> start pulse -> wait for done (or timeout) -> response.
module aes_req_sched #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int TMO_CYC = 63
) (
  input logic            clk,
  input logic            rst,
  aes_req_sched_if.slave bus
);
  localparam int CNT_W = $clog2(TMO_CYC + 1);

  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

  state_t             state;
  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    gnt_idx;
  logic [NUM_REQ-1:0] gnt_oh;
  logic               gnt_any;
  int                 best_dist;
  logic [CNT_W-1:0]   cnt;
  logic               tmo;

  logic               st_aes;
  logic [127:0]       aes_key;
  logic [127:0]       plain_text;
  logic               rsp_vld;
  logic [ID_W-1:0]    rsp_id;
  logic [127:0]       rsp_ct;
  logic               rsp_err;
  logic               busy;

  // Pick the valid requester closest above the pointer (wrapping); pointer itself is distance 0.
  always_comb begin
    best_dist = NUM_REQ;
    gnt_idx   = '0;
    gnt_any   = 1'b0;
    gnt_oh    = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (bus.req_vld[r] && (((r + NUM_REQ - int'(ptr)) % NUM_REQ) < best_dist)) begin
        best_dist = (r + NUM_REQ - int'(ptr)) % NUM_REQ;
        gnt_idx   = ID_W'(r);
        gnt_any   = 1'b1;
      end
    end
    if (gnt_any) gnt_oh = NUM_REQ'(1) << gnt_idx;
  end

  // Last WAIT cycle: the counter starts at 0 in the first WAIT cycle.
  assign tmo = (cnt == CNT_W'(TMO_CYC - 1));

  // Accept is combinational so the requester sees ready in the same cycle it is granted.
  assign bus.req_rdy    = (state == IDLE) ? gnt_oh : '0;
  assign bus.st_aes     = st_aes;
  assign bus.aes_key    = aes_key;
  assign bus.plain_text = plain_text;
  assign bus.rsp_vld    = rsp_vld;
  assign bus.rsp_id     = rsp_id;
  assign bus.rsp_ct     = rsp_ct;
  assign bus.rsp_err    = rsp_err;
  assign bus.busy       = busy;

  // Job FSM with registered outputs; done is only honoured in WAIT, and wins over timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      cnt        <= '0;
      st_aes     <= 1'b0;
      aes_key    <= '0;
      plain_text <= '0;
      rsp_vld    <= 1'b0;
      rsp_id     <= '0;
      rsp_ct     <= '0;
      rsp_err    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      st_aes <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt_any) begin
            state      <= START;
            busy       <= 1'b1;
            st_aes     <= 1'b1;
            rsp_id     <= gnt_idx;
            aes_key    <= bus.req_key[gnt_idx];
            plain_text <= bus.req_pt[gnt_idx];
          end
        end
        START: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          cnt <= cnt + 1'b1;
          if (bus.aes_done) begin
            rsp_ct  <= bus.cp_text;
            rsp_err <= 1'b0;
            rsp_vld <= 1'b1;
            state   <= RESP;
          end else if (tmo) begin
            rsp_ct  <= '0;
            rsp_err <= 1'b1;
            rsp_vld <= 1'b1;
            state   <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_rdy) begin
            rsp_vld <= 1'b0;
            busy    <= 1'b0;
            state   <= IDLE;
            ptr     <= (rsp_id == ID_W'(NUM_REQ - 1)) ? '0 : rsp_id + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_req_sched.sv
// Bench for aes_req_sched: directed scenarios with literal expectations, then
// randomized traffic, all checked every cycle against a job-timeline model.
module tb_aes_req_sched;
  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int TMO = 63;
  localparam int RND = 0, FIX = 1, NEVER = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  aes_req_sched_if #(.NUM_REQ(N), .ID_W(IDW)) bus ();
  aes_req_sched #(.NUM_REQ(N), .ID_W(IDW), .TMO_CYC(TMO)) dut (.clk(clk), .rst(rst), .bus(bus));

  int cyc = 0;
  // Global cycle index shared by stimulus, core model and checker.
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- behavioural model: one job described by its timeline ----------------
  bit           m_busy = 0, m_resp = 0, m_err = 0, m_wait_nx = 0;
  int           m_ptr = 0, m_g = 0, m_acc = 0;
  logic [127:0] m_key = '0, m_pt = '0, m_ct = '0;

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      int j;
      j = (p + k) % N;
      if (v[j[$clog2(N)-1:0]]) return j;
    end
    return -1;
  endfunction

  // Compare outputs against the model mid-cycle, then advance the model across the coming edge.
  always @(negedge clk) begin : cmp
    int p;
    bit e_start, e_wait;
    logic [N-1:0] e_rdy;
    p       = pick(bus.req_vld, m_ptr);
    e_start = m_busy && (cyc == m_acc + 1);
    e_wait  = m_busy && !m_resp && (cyc > m_acc + 1);
    e_rdy   = '0;
    if (!m_busy && p >= 0) e_rdy = N'(1) << p;
    if (chk_en) begin
      chk("req_rdy", bus.req_rdy, e_rdy);
      chk("st_aes", bus.st_aes, e_start);
      chk("busy", bus.busy, m_busy);
      chk("rsp_vld", bus.rsp_vld, m_resp);
      if (m_resp) begin
        chk("rsp_id", bus.rsp_id, m_g);
        chk("rsp_ct", bus.rsp_ct, m_ct);
        chk("rsp_err", bus.rsp_err, m_err);
      end
      if (e_start || e_wait) begin
        chk("aes_key", bus.aes_key, m_key);
        chk("plain_text", bus.plain_text, m_pt);
      end
    end
    if (rst) begin
      m_busy = 0; m_resp = 0; m_err = 0; m_ptr = 0; m_ct = '0;
    end else if (!m_busy) begin
      if (p >= 0) begin
        m_busy = 1; m_acc = cyc; m_g = p;
        m_key = bus.req_key[p]; m_pt = bus.req_pt[p];
      end
    end else if (e_wait) begin
      if (bus.aes_done === 1'b1) begin
        m_resp = 1; m_err = 0; m_ct = bus.cp_text;
      end else if (cyc == m_acc + 1 + TMO) begin
        m_resp = 1; m_err = 1; m_ct = '0;
      end
    end else if (m_resp && bus.rsp_rdy) begin
      m_busy = 0; m_resp = 0; m_ptr = (m_g + 1) % N;
    end
    m_wait_nx = m_busy && !m_resp && (cyc + 1 > m_acc + 1);
  end

  // ---------------- AES core stand-in ----------------
  int           core_mode = RND, core_lat = 1, done_at = -1;
  logic [127:0] core_ct = '0;

  // Pulses done at the scheduled cycle; in random mode also throws stray dones outside WAIT.
  always @(posedge clk) begin : core
    #1;
    bus.aes_done = 1'b0;
    bus.cp_text  = rnd128();
    if (cyc == done_at) begin
      bus.aes_done = 1'b1;
      if (core_mode == FIX) bus.cp_text = core_ct;
    end else if (core_mode == RND && !m_wait_nx && $urandom_range(0, 7) == 0) begin
      bus.aes_done = 1'b1;
    end
    if (bus.st_aes === 1'b1) begin
      case (core_mode)
        FIX:   done_at = cyc + core_lat;
        NEVER: done_at = cyc + TMO + 2;
        default: begin
          case ($urandom_range(0, 9))
            0, 1, 2, 3, 4: done_at = cyc + $urandom_range(1, 10);
            5:             done_at = cyc + TMO;
            6:             done_at = cyc + TMO + $urandom_range(1, 3);
            7:             done_at = -1;
            default:       done_at = cyc + $urandom_range(1, TMO);
          endcase
        end
      endcase
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bus.rsp_rdy = 1'b1;
    for (int k = 0; k < 200 && bus.busy; k++) tick();
    if (bus.busy) chk("drain_bound", bus.busy, 1'b0);
    bus.rsp_rdy = 1'b0;
  endtask

  task automatic run_job(input int r, output int st_c, output int vld_c, output int n_st);
    st_c = -1; vld_c = -1; n_st = 0;
    bus.req_vld[r] = 1'b1;
    for (int k = 0; k < 200; k++) begin
      tick();
      if (bus.busy) bus.req_vld[r] = 1'b0;
      if (bus.st_aes) begin n_st++; st_c = cyc; end
      if (bus.rsp_vld) begin vld_c = cyc; break; end
    end
    bus.req_vld[r] = 1'b0;
    if (vld_c < 0) chk("job_rsp_bound", 1'b0, 1'b1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, bus.busy, '0);
    chk({tag, "_rsp_vld"}, bus.rsp_vld, '0);
    chk({tag, "_st_aes"}, bus.st_aes, '0);
    chk({tag, "_aes_key"}, bus.aes_key, '0);
    chk({tag, "_plain_text"}, bus.plain_text, '0);
    chk({tag, "_rsp_ct"}, bus.rsp_ct, '0);
    chk({tag, "_rsp_err"}, bus.rsp_err, '0);
    chk({tag, "_rsp_id"}, bus.rsp_id, '0);
    chk({tag, "_req_rdy"}, bus.req_rdy, '0);
  endtask

  initial begin : stim
    int st_c, vld_c, n_st, ng, got;
    logic [N-1:0] exp_g [5];
    logic [N-1:0] seen;

    rst = 1'b1;
    bus.req_vld = '0;
    bus.rsp_rdy = 1'b0;
    for (int r = 0; r < N; r++) begin bus.req_key[r] = '0; bus.req_pt[r] = '0; end
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    chk_zero("reset");

    // 1: known vector, single start pulse, latency done+1
    core_mode = FIX; core_lat = 5;
    core_ct = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    bus.req_key[0] = 128'h000102030405060708090a0b0c0d0e0f;
    bus.req_pt[0]  = 128'h00112233445566778899aabbccddeeff;
    run_job(0, st_c, vld_c, n_st);
    chk("t1_start_pulses", n_st, 1);
    chk("t1_latency", vld_c - st_c, core_lat + 1);
    chk("t1_rsp_id", bus.rsp_id, 0);
    chk("t1_rsp_ct", bus.rsp_ct, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    chk("t1_rsp_err", bus.rsp_err, 0);
    chk("t1_key_held", bus.aes_key, 128'h000102030405060708090a0b0c0d0e0f);
    bus.rsp_rdy = 1'b1; tick(); bus.rsp_rdy = 1'b0;

    // 2: all requesters held from reset -> 0,1,2,3,0
    rst = 1'b1;
    for (int r = 0; r < N; r++) begin bus.req_key[r] = rnd128(); bus.req_pt[r] = rnd128(); end
    bus.req_vld = '1;
    tick();
    rst = 1'b0;
    core_lat = 2;
    bus.rsp_rdy = 1'b1;
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    ng = 0;
    for (int k = 0; k < 100 && ng < 5; k++) begin
      seen = bus.req_rdy;
      if (seen != '0) begin
        chk($sformatf("t2_grant%0d", ng), seen, exp_g[ng]);
        ng++;
      end
      tick();
    end
    chk("t2_grant_count", ng, 5);
    bus.req_vld = '0;
    drain();

    // 3: core never answers -> timeout response; 4: consumer stalls 20 cycles
    core_mode = NEVER;
    bus.req_key[2] = rnd128(); bus.req_pt[2] = rnd128();
    run_job(2, st_c, vld_c, n_st);
    chk("t3_latency", vld_c - st_c, TMO + 1);
    chk("t3_rsp_err", bus.rsp_err, 1);
    chk("t3_rsp_ct", bus.rsp_ct, 0);
    chk("t3_rsp_id", bus.rsp_id, 2);
    bus.req_key[1] = rnd128(); bus.req_pt[1] = rnd128();
    bus.req_vld = 4'b0010;
    for (int k = 0; k < 20; k++) begin
      chk("t4_no_rdy", bus.req_rdy, 0);
      chk("t4_rsp_vld", bus.rsp_vld, 1);
      tick();
    end
    chk("t4_err_after_late_done", bus.rsp_err, 1);
    chk("t4_ct_after_late_done", bus.rsp_ct, 0);
    core_mode = FIX; core_lat = 3;
    bus.rsp_rdy = 1'b1; tick(); bus.rsp_rdy = 1'b0;
    chk("t4_grant1", bus.req_rdy, 4'b0010);
    tick();
    bus.req_vld = '0;
    drain();

    // 5: done lands on the last WAIT cycle -> done wins
    core_lat = TMO;
    core_ct = 128'hdeadbeef_0123_4567_89ab_cdef_cafef00d;
    bus.req_key[2] = rnd128(); bus.req_pt[2] = rnd128();
    run_job(2, st_c, vld_c, n_st);
    chk("t5_rsp_err", bus.rsp_err, 0);
    chk("t5_rsp_ct", bus.rsp_ct, 128'hdeadbeef_0123_4567_89ab_cdef_cafef00d);
    chk("t5_latency", vld_c - st_c, TMO + 1);
    chk("t5_rsp_id", bus.rsp_id, 2);
    bus.rsp_rdy = 1'b1; tick(); bus.rsp_rdy = 1'b0;

    // 6: reset during WAIT -> all zero, pointer back to 0
    core_mode = NEVER;
    bus.req_key[3] = rnd128(); bus.req_pt[3] = rnd128();
    bus.req_vld[3] = 1'b1;
    got = 0;
    for (int k = 0; k < 20 && got == 0; k++) begin
      tick();
      if (bus.busy) bus.req_vld[3] = 1'b0;
      if (bus.st_aes) got = 1;
    end
    chk("t6_started", got, 1);
    repeat (5) tick();
    chk("t6_busy_in_wait", bus.busy, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk_zero("t6");
    core_mode = FIX; core_lat = 4;
    bus.req_vld = 4'b1001;
    #1;
    chk("t6_ptr0_grant", bus.req_rdy, 4'b0001);
    tick();
    bus.req_vld = '0;
    drain();

    // randomized traffic
    core_mode = RND;
    for (int k = 0; k < 4000; k++) begin
      for (int r = 0; r < N; r++) begin
        if (!bus.req_vld[r]) begin
          if ($urandom_range(0, 5) == 0) begin
            bus.req_vld[r] = 1'b1;
            bus.req_key[r] = rnd128();
            bus.req_pt[r]  = rnd128();
          end
        end else if ($urandom_range(0, 11) == 0) begin
          bus.req_vld[r] = 1'b0;
        end
      end
      bus.rsp_rdy = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0;
    bus.req_vld = '0;
    drain();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Hard stop if the bench itself wedges.
  initial begin
    #2000000;
    $display("FAIL watchdog expired at cyc %0d", cyc);
    $fatal(1);
  end
endmodule
